countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Countdown controller that sits directly downstream of the keypad decoder. It consumes the keypad's one-cycle event pulses (digit, confirm, clear, start), assembles an MM:SS entry, and runs a 1 Hz BCD countdown with pause/resume. It drives four BCD digits plus status flags to the display and alarm stages.

## Interface
- TICK_DIV, default 100_000_000: clk cycles per countdown second. Minimum 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- keydown_num  in  1  one-cycle pulse: digit key pressed.
- num  in  4  key code, valid only while keydown_num=1.
- keydown_confirm  in  1  one-cycle pulse: confirm key.
- keydown_clear  in  1  one-cycle pulse: clear key.
- keydown_start  in  1  one-cycle pulse: start/pause key.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits, registered.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE; drives the alarm.
- err  out  1  one-cycle pulse when a confirm is rejected.

## Operation
- States: IDLE, ENTRY, READY, RUN, PAUSE, DONE.
- Event priority within one cycle: clear > start > confirm > num. Only the highest-priority event present is acted on.
- num > 9: ignored in every state, with no state or digit change.
- Digit shift (ENTRY): the new digit enters sec_ones. Existing digits move left: sec_ones→sec_tens→min_ones→min_tens. The old min_tens is discarded.
- IDLE: digits 00:00.
  - num → ENTRY; digits become 000d.
  - start and confirm are ignored.
- ENTRY:
  - num → shift.
  - clear → IDLE, digits zeroed.
  - confirm:
    - Rejected if sec_tens > 5 or all digits are 0. On reject: err pulses, stay in ENTRY, digits unchanged.
    - Otherwise → READY.
  - start is ignored.
- READY: the loaded value is displayed.
  - start → RUN and the prescaler clears.
  - num → ENTRY; digits become 000d.
  - clear → IDLE.
- RUN: the prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the digits decrement once (a tick).
  - start → PAUSE; the prescaler value is held.
  - clear → IDLE.
  - num and confirm are ignored.
- BCD decrement, with borrow chain:
  - sec_ones 0→9, borrow.
  - sec_tens 0→5, borrow.
  - min_ones 0→9, borrow.
  - min_tens minus 1.
  - Example: 10:00 → 09:59.
- A tick that produces 00:00 moves to DONE on the same edge.
- PAUSE: digits frozen.
  - start → RUN, resuming from the held prescaler value.
  - clear → IDLE.
- DONE: digits stay 00:00 and done=1.
  - start or clear → IDLE.
  - num and confirm are ignored.
- Any → IDLE asynchronously while rst_n=0.

## Timing
- Reset values: state IDLE, all digits 0, running=0, paused=0, done=0, err=0, prescaler 0.
- Event-to-output latency: 1 cycle. The pulse is sampled at edge N; digits and flags are valid after edge N.
- err is high for exactly the cycle after the rejecting edge.
- First tick lands TICK_DIV cycles after the start edge. Later ticks follow every TICK_DIV cycles while in RUN.
- Pause/resume: total RUN cycles between ticks stays TICK_DIV. The prescaler is never reset by PAUSE.
- start coincident with a tick edge in RUN: PAUSE wins and the tick is dropped. The prescaler holds at TICK_DIV-1, so the tick fires on the first RUN cycle after resume.
- clear coincident with a tick: IDLE; the tick is discarded.
- Maximum entry 99:59. No overflow is possible since the value only decrements.
- The prescaler is wide enough for TICK_DIV-1 ($clog2(TICK_DIV)).

## Test plan
All scenarios run with TICK_DIV=4.
- Reset: hold rst_n=0 mid-RUN → all outputs 0 and IDLE immediately (async). Release → no tick until start.
- Entry shift: num 1,2,3,4,5 → digits 23:45. Confirm → READY, err=0.
- Invalid confirm:
  - Enter 0,1,7,0 (01:70) then confirm → err one cycle, state ENTRY, digits 01:70.
  - Clear → 00:00, IDLE.
  - In IDLE, confirm with 00:00 → ignored, no err.
- Countdown with borrow: load 01:00, start → 00:59 exactly 4 cycles after the start edge, then 00:58 at 8 cycles. Load 00:02, start → done=1 at cycle 8, digits 00:00, running=0.
- Pause: load 00:05, start, start again 2 cycles later → paused=1, digits frozen 20+ cycles. Start → first tick 2 cycles later.
- Priority and ignores:
  - clear and start in the same cycle during RUN → IDLE.
  - num=0xA in ENTRY → no change.
  - num during RUN → ignored.
  - start in DONE → IDLE, done=0.

Source files
------------

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Consumes one-cycle keypad event pulses, assembles an MM:SS entry and runs
//   a BCD countdown (one decrement every TICK_DIV clocks) with pause/resume.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   keydown_num, num     digit key pulse and its key code (codes > 9 ignored)
//   keydown_confirm      confirm key pulse (loads the entry)
//   keydown_clear        clear key pulse (back to idle, digits zeroed)
//   keydown_start        start/pause key pulse
//   min_tens..sec_ones   registered BCD display digits
//   running/paused/done  status flags for RUN / PAUSE / DONE
//   err                  one-cycle pulse after a rejected confirm
module countdown_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       keydown_num,
  input  logic [3:0] num,
  input  logic       keydown_confirm,
  input  logic       keydown_clear,
  input  logic       keydown_start,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       err
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_READY, S_RUN, S_PAUSE, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      mt_nxt, mo_nxt, st_nxt, so_nxt;
  logic [3:0]      dec_mt, dec_mo, dec_st, dec_so;
  logic            dec_zero;
  logic [PW-1:0]   presc, presc_nxt;
  logic            err_nxt;
  logic            num_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      presc    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      min_tens <= mt_nxt;
      min_ones <= mo_nxt;
      sec_tens <= st_nxt;
      sec_ones <= so_nxt;
      presc    <= presc_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mt_nxt    = min_tens;
    mo_nxt    = min_ones;
    st_nxt    = sec_tens;
    so_nxt    = sec_ones;
    presc_nxt = presc;
    err_nxt   = 1'b0;
    num_ok    = keydown_num && (num <= 4'd9);

    // BCD decrement with borrow chain (seconds tens wrap to 5)
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      dec_st = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        dec_st = 4'd5;
        dec_mo = min_ones - 4'd1;
        if (min_ones == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
    dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);

    if (keydown_clear) begin
      state_nxt = S_IDLE;
      mt_nxt    = '0;
      mo_nxt    = '0;
      st_nxt    = '0;
      so_nxt    = '0;
      presc_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!keydown_start && !keydown_confirm && num_ok) begin
            state_nxt = S_ENTRY;
            so_nxt    = num;
          end
        end
        S_ENTRY: begin
          if (keydown_start) begin
            state_nxt = S_ENTRY;
          end else if (keydown_confirm) begin
            if (sec_tens > 4'd5 ||
                {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000)
              err_nxt = 1'b1;
            else
              state_nxt = S_READY;
          end else if (num_ok) begin
            mt_nxt = min_ones;
            mo_nxt = sec_tens;
            st_nxt = sec_ones;
            so_nxt = num;
          end
        end
        S_READY: begin
          if (keydown_start) begin
            state_nxt = S_RUN;
            presc_nxt = '0;
          end else if (!keydown_confirm && num_ok) begin
            state_nxt = S_ENTRY;
            mt_nxt    = '0;
            mo_nxt    = '0;
            st_nxt    = '0;
            so_nxt    = num;
          end
        end
        S_RUN: begin
          if (keydown_start) begin
            // The pausing cycle still counts as a RUN cycle, but a tick due
            // on this edge is dropped: the prescaler saturates at TICK_DIV-1
            // so that tick fires on the first RUN cycle after resume.
            state_nxt = S_PAUSE;
            if (presc != PMAX)
              presc_nxt = presc + PW'(1);
          end else if (presc == PMAX) begin
            presc_nxt = '0;
            mt_nxt    = dec_mt;
            mo_nxt    = dec_mo;
            st_nxt    = dec_st;
            so_nxt    = dec_so;
            if (dec_zero)
              state_nxt = S_DONE;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (keydown_start)
            state_nxt = S_RUN;
        end
        S_DONE: begin
          if (keydown_start) begin
            state_nxt = S_IDLE;
            mt_nxt    = '0;
            mo_nxt    = '0;
            st_nxt    = '0;
            so_nxt    = '0;
            presc_nxt = '0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign running = (state == S_RUN);
  assign paused  = (state == S_PAUSE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       keydown_num = 1'b0;
  logic [3:0] num = '0;
  logic       keydown_confirm = 1'b0;
  logic       keydown_clear = 1'b0;
  logic       keydown_start = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, paused, done, err;

  int checks = 0;
  int errors = 0;

  countdown_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .keydown_num(keydown_num), .num(num),
    .keydown_confirm(keydown_confirm), .keydown_clear(keydown_clear),
    .keydown_start(keydown_start),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .paused(paused), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // outputs packed as {digits[15:0], running, paused, done, err}
  function automatic logic [19:0] outv();
    return {min_tens, min_ones, sec_tens, sec_ones, running, paused, done, err};
  endfunction

  task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic f,
                      input logic k, input logic [3:0] n);
    @(negedge clk);
    keydown_clear = c; keydown_start = s; keydown_confirm = f;
    keydown_num = k; num = n;
    @(posedge clk);
    #1;
    keydown_clear = 0; keydown_start = 0; keydown_confirm = 0; keydown_num = 0;
  endtask

  task automatic idle_chk(input string nm, input logic [15:0] d, input logic [3:0] fl);
    step(0, 0, 0, 0, 4'd0);
    chk(nm, outv(), {d, fl});
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    step(0, 0, 0, 1, a);
    step(0, 0, 0, 1, b);
    step(0, 0, 0, 1, c);
    step(0, 0, 0, 1, d);
    step(0, 0, 1, 0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       c, s, f, k;
    logic [3:0] n;
    logic [15:0] dig;
    logic [3:0]  flg;   // {running, paused, done, err}
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic c, input logic s, input logic f, input logic k,
                      input logic [3:0] n, input logic [15:0] dig, input logic [3:0] flg);
    vec_t v;
    v.c = c; v.s = s; v.f = f; v.k = k; v.n = n; v.dig = dig; v.flg = flg;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Value is kept as a decimal entry number while editing and as a plain
  // count of seconds while counting; the display is derived arithmetically.
  localparam int MI = 0, ME = 1, MR = 2, MRUN = 3, MP = 4, MD = 5;
  int m_mode, m_entry, m_secs, m_runcyc;
  bit m_err;

  task automatic m_init();
    m_mode = MI; m_entry = 0; m_secs = 0; m_runcyc = 0; m_err = 0;
  endtask

  task automatic m_step(input bit c, input bit s, input bit f, input bit k, input int n);
    m_err = 0;
    if (c) begin
      m_mode = MI; m_entry = 0; m_secs = 0; m_runcyc = 0;
    end else if (s) begin
      if (m_mode == MR) begin
        m_mode = MRUN; m_secs = (m_entry / 100) * 60 + m_entry % 100; m_runcyc = 0;
      end else if (m_mode == MRUN) begin
        m_mode = MP;
        if (m_runcyc + 1 < TD) m_runcyc++;
      end else if (m_mode == MP) begin
        m_mode = MRUN;
      end else if (m_mode == MD) begin
        m_mode = MI; m_entry = 0;
      end
    end else if (m_mode == MRUN) begin
      m_runcyc++;
      if (m_runcyc == TD) begin
        m_runcyc = 0;
        m_secs--;
        if (m_secs == 0) m_mode = MD;
      end
    end else if (f) begin
      if (m_mode == ME) begin
        if (((m_entry / 10) % 10) > 5 || m_entry == 0) m_err = 1;
        else m_mode = MR;
      end
    end else if (k && n <= 9) begin
      if (m_mode == MI || m_mode == MR) begin
        m_mode = ME; m_entry = n;
      end else if (m_mode == ME) begin
        m_entry = (m_entry * 10 + n) % 10000;
      end
    end
  endtask

  function automatic logic [19:0] m_out();
    int a, b, c, d, mm, ss;
    if (m_mode == MRUN || m_mode == MP || m_mode == MD) begin
      mm = m_secs / 60; ss = m_secs % 60;
      a = mm / 10; b = mm % 10; c = ss / 10; d = ss % 10;
    end else begin
      a = m_entry / 1000; b = (m_entry / 100) % 10; c = (m_entry / 10) % 10; d = m_entry % 10;
    end
    return {4'(a), 4'(b), 4'(c), 4'(d),
            m_mode == MRUN, m_mode == MP, m_mode == MD, m_err};
  endfunction

  initial begin
    // reset state
    @(posedge clk);
    #1;
    chk("reset_held", outv(), 20'h0);
    @(negedge clk);
    rst_n = 1;
    idle_chk("reset_idle", 16'h0000, 4'b0000);

    // table: entry, invalid confirms, ignores, countdown with borrow, priority
    addv(0,0,0,1,4'd1, 16'h0001, 4'b0000);
    addv(0,0,0,1,4'd2, 16'h0012, 4'b0000);
    addv(0,0,0,1,4'd3, 16'h0123, 4'b0000);
    addv(0,0,0,1,4'd4, 16'h1234, 4'b0000);
    addv(0,0,0,1,4'd5, 16'h2345, 4'b0000);
    addv(0,0,1,0,4'd0, 16'h2345, 4'b0000);
    addv(0,0,0,1,4'hB, 16'h2345, 4'b0000);
    addv(1,0,0,0,4'd0, 16'h0000, 4'b0000);
    addv(0,0,0,1,4'd0, 16'h0000, 4'b0000);
    addv(0,0,0,1,4'd1, 16'h0001, 4'b0000);
    addv(0,0,0,1,4'd7, 16'h0017, 4'b0000);
    addv(0,0,0,1,4'd0, 16'h0170, 4'b0000);
    addv(0,0,1,0,4'd0, 16'h0170, 4'b0001);
    addv(0,0,0,0,4'd0, 16'h0170, 4'b0000);
    addv(0,0,0,1,4'hA, 16'h0170, 4'b0000);
    addv(0,0,1,0,4'd0, 16'h0170, 4'b0001);
    addv(1,0,0,0,4'd0, 16'h0000, 4'b0000);
    addv(0,0,1,0,4'd0, 16'h0000, 4'b0000);
    addv(0,1,0,0,4'd0, 16'h0000, 4'b0000);
    addv(0,1,0,1,4'd3, 16'h0000, 4'b0000);
    addv(0,0,0,1,4'd0, 16'h0000, 4'b0000);
    addv(0,0,1,0,4'd0, 16'h0000, 4'b0001);
    addv(0,0,0,1,4'd1, 16'h0001, 4'b0000);
    addv(0,0,0,1,4'd0, 16'h0010, 4'b0000);
    addv(0,0,0,1,4'd0, 16'h0100, 4'b0000);
    addv(0,0,1,0,4'd0, 16'h0100, 4'b0000);
    addv(0,1,0,0,4'd0, 16'h0100, 4'b1000);
    addv(0,0,0,0,4'd0, 16'h0100, 4'b1000);
    addv(0,0,0,0,4'd0, 16'h0100, 4'b1000);
    addv(0,0,0,0,4'd0, 16'h0100, 4'b1000);
    addv(0,0,0,0,4'd0, 16'h0059, 4'b1000);
    addv(0,0,0,1,4'd5, 16'h0059, 4'b1000);
    addv(0,0,1,0,4'd0, 16'h0059, 4'b1000);
    addv(0,0,0,0,4'd0, 16'h0059, 4'b1000);
    addv(0,0,0,0,4'd0, 16'h0058, 4'b1000);
    addv(1,1,0,0,4'd0, 16'h0000, 4'b0000);
    addv(0,0,0,0,4'd0, 16'h0000, 4'b0000);
    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].s, vecs[i].f, vecs[i].k, vecs[i].n);
      chk($sformatf("vec%0d", i), outv(), {vecs[i].dig, vecs[i].flg});
    end

    // 00:02 runs to DONE on the 8th cycle after start; start in DONE -> IDLE
    enter4(0, 0, 0, 2);
    step(0, 1, 0, 0, 4'd0);
    chk("done_start", outv(), {16'h0002, 4'b1000});
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 4'd0);
      if (i == 8)      chk("done_reached", outv(), {16'h0000, 4'b0010});
      else if (i >= 4) chk($sformatf("done_c%0d", i), outv(), {16'h0001, 4'b1000});
      else             chk($sformatf("done_c%0d", i), outv(), {16'h0002, 4'b1000});
    end
    step(0, 1, 0, 0, 4'd0);
    chk("done_start_idle", outv(), {16'h0000, 4'b0000});

    // pause two cycles after start, resume: tick two cycles after resume
    enter4(0, 0, 0, 5);
    step(0, 1, 0, 0, 4'd0);
    idle_chk("pause_e1", 16'h0005, 4'b1000);
    step(0, 1, 0, 0, 4'd0);
    chk("pause_enter", outv(), {16'h0005, 4'b0100});
    for (int i = 0; i < 20; i++) idle_chk($sformatf("pause_hold%0d", i), 16'h0005, 4'b0100);
    step(0, 1, 0, 0, 4'd0);
    chk("resume", outv(), {16'h0005, 4'b1000});
    idle_chk("resume_r1", 16'h0005, 4'b1000);
    idle_chk("resume_tick", 16'h0004, 4'b1000);
    step(1, 0, 0, 0, 4'd0);

    // start on a tick edge: tick dropped, fires first RUN cycle after resume;
    // clear on a tick edge discards the tick
    enter4(0, 0, 0, 9);
    step(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) idle_chk($sformatf("coin_run%0d", i), 16'h0009, 4'b1000);
    step(0, 1, 0, 0, 4'd0);
    chk("coin_pause", outv(), {16'h0009, 4'b0100});
    idle_chk("coin_hold", 16'h0009, 4'b0100);
    step(0, 1, 0, 0, 4'd0);
    chk("coin_resume", outv(), {16'h0009, 4'b1000});
    idle_chk("coin_tick", 16'h0008, 4'b1000);
    for (int i = 0; i < 3; i++) idle_chk($sformatf("coin_wait%0d", i), 16'h0008, 4'b1000);
    step(1, 0, 0, 0, 4'd0);
    chk("coin_clear", outv(), {16'h0000, 4'b0000});

    // asynchronous reset mid-RUN, then no ticks without start
    enter4(0, 0, 0, 5);
    step(0, 1, 0, 0, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_reset", outv(), 20'h0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) idle_chk($sformatf("post_reset%0d", i), 16'h0000, 4'b0000);

    // randomized run against the reference model
    do_reset();
    m_init();
    for (int i = 0; i < 3000; i++) begin
      logic c, s, f, k;
      logic [3:0] n;
      c = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 11) == 0);
      f = ($urandom_range(0, 7) == 0);
      k = ($urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 3));
      step(c, s, f, k, n);
      m_step(c, s, f, k, int'(n));
      chk($sformatf("rand%0d", i), outv(), m_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
